exec_unit_bank: RTL and testbench
=================================

// Module: exec_unit_bank
// PURPOSE
// Execution-side endpoint of the reservation-station issue interface. Holds two single-cycle
// ALU lanes (0,1) and one load/store lane (2) backed by a private word-addressed data memory.
// Accepts issued operations per lane and returns completions on a 3-lane result bus.
// The result bus carries valid, rd, value and ROB index, and feeds register-ready and
// operand forwarding.
// PARAMETERS
// MEM_LAT  3   cycles from lane-2 accept to lane-2 completion; legal range 1..15
// DEPTH    256 data memory words; must be a power of two
// PORTS
// clk          in   1      rising-edge clock
// rst_n        in   1      asynchronous active-low reset
// iss_valid    in   3      per-lane issue strobe; bit k = lane k
// iss_opcode   in   3x7    packed {lane2,lane1,lane0}; 0110011 R, 0010011 I, 0000011 LW, 0100011 SW
// iss_alu_op   in   3x3    ALU function per lane
// iss_rd       in   3x6    destination register per lane
// iss_src1     in   3x32   operand A value per lane
// iss_src2     in   3x32   operand B value per lane; SW store data on lane 2
// iss_imm      in   3x32   sign-extended immediate per lane
// iss_rob      in   3x5    ROB index per lane
// fu_ready     out  3      1 = lane k accepts an issue this cycle
// cdb_valid    out  3      1-cycle completion pulse per lane
// cdb_wen      out  3      1 = completion writes rd; 0 for SW
// cdb_rd       out  3x6    completing rd per lane
// cdb_val      out  3x32   result value per lane
// cdb_rob      out  3x5    completing ROB index per lane
// err_o        out  1      sticky: issue to a non-ready lane, or a bad opcode on any lane
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - cdb_* = 0 and err_o = 0.
//   - fu_ready = 3'b111.
//   - Lane-2 FSM enters IDLE.
//   - Memory contents are not reset.
// - Accept: lane k accepts when iss_valid[k] && fu_ready[k] at a rising edge.
//   - Issue to a non-ready lane: dropped, err_o set.
// - ALU lanes 0/1:
//   - fu_ready[0], fu_ready[1] are always 1.
//   - Completion is registered: cdb_valid[k]=1 exactly one cycle after accept, and
//     for one cycle only.
//   - Back-to-back accepts give back-to-back completions.
//   - Operand B is src2 for R-type and imm for I-type.
//   - alu_op: 000 ADD, 001 SUB, 010 XOR, 011 SRA (shift amount = B[4:0]), 100 AND; others give 0.
//   - Arithmetic is mod 2^32 with no overflow flag.
//   - cdb_wen = 1.
//   - Opcode not R/I on lanes 0/1: no completion, err_o set.
// - Lane 2 FSM: IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: fu_ready[2]=1. On accept, latch addr = src1+imm (32-bit wrap), opcode, src2, rd, rob.
//     The cycle counter loads MEM_LAT-1. Go to BUSY, or directly to DONE if MEM_LAT=1.
//   - BUSY: counter decrements each cycle; at 1, go to DONE.
//   - DONE: drive cdb_valid[2]=1 for one cycle, then return to IDLE.
//   - fu_ready[2]=0 in BUSY and DONE. The next accept is possible the cycle after the DONE pulse.
//   - Completion pulse arrives exactly MEM_LAT cycles after the accept edge.
//   - Memory index = addr[log2(DEPTH)+1:2]. Upper and low bits are ignored; out-of-range
//     addresses wrap.
//   - LW: cdb_val = mem[index], cdb_wen=1.
//   - SW: mem[index] <= src2 on entering DONE; cdb_val=0, cdb_wen=0, cdb_rob valid.
//   - Non-memory opcode on lane 2: not accepted, err_o set, FSM stays IDLE.
// - Simultaneous completions on all three lanes in one cycle are legal; there is no
//   arbitration.
// - When cdb_valid[k]=0, cdb_rd/val/rob/wen[k] hold 0.
// - Reset mid-operation abandons the in-flight lane-2 op:
//   - no completion is emitted;
//   - a pending SW is not written.
// TESTING
// - Lane0 R ADD src1=5 src2=7 rd=3 rob=4 -> next cycle cdb_valid=001, rd=3, val=12, rob=4, wen=1.
// - Lane1 R SRA src1=0x80000000 src2=4, then I AND src1=0xFF imm=0x0F on the next cycle
//   -> consecutive cdb_val[1]=0xF8000000 then 0x0000000F.
// - MEM_LAT=3: lane2 SW src1=0x10 imm=0 src2=0xDEADBEEF -> wen=0 pulse 3 cycles after accept.
//   Then LW same address -> val=0xDEADBEEF 3 cycles after its accept.
// - Lane2 busy, iss_valid[2]=1 again -> fu_ready[2]=0, issue dropped, err_o=1 and sticky
//   until reset.
// - All three lanes issued in the same cycle with MEM_LAT=1 -> cdb_valid=111 on the same
//   cycle with correct per-lane fields.
// - rst_n low while lane2 is in BUSY with a SW -> outputs 0 immediately, fu_ready=111,
//   no pulse; a later LW of that address returns the old value.

Source files
------------

// File: rtl/exec_unit_bank_if.sv
// Issue and completion bundle between the reservation stations
// and the execution lane bank. Lane k occupies slice [k] of each field.
interface exec_unit_bank_if;
  logic [2:0]       iss_valid;
  logic [2:0][6:0]  iss_opcode;
  logic [2:0][2:0]  iss_alu_op;
  logic [2:0][5:0]  iss_rd;
  logic [2:0][31:0] iss_src1;
  logic [2:0][31:0] iss_src2;
  logic [2:0][31:0] iss_imm;
  logic [2:0][4:0]  iss_rob;
  logic [2:0]       fu_ready;
  logic [2:0]       cdb_valid;
  logic [2:0]       cdb_wen;
  logic [2:0][5:0]  cdb_rd;
  logic [2:0][31:0] cdb_val;
  logic [2:0][4:0]  cdb_rob;

  modport master (
    output iss_valid, iss_opcode, iss_alu_op, iss_rd,
    output iss_src1, iss_src2, iss_imm, iss_rob,
    input  fu_ready, cdb_valid, cdb_wen, cdb_rd,
    input  cdb_val, cdb_rob
  );

  modport slave (
    input  iss_valid, iss_opcode, iss_alu_op, iss_rd,
    input  iss_src1, iss_src2, iss_imm, iss_rob,
    output fu_ready, cdb_valid, cdb_wen, cdb_rd,
    output cdb_val, cdb_rob
  );
endinterface

// File: rtl/exec_unit_bank.sv
// Two single-cycle ALU lanes plus one load/store lane with a private
// word-addressed memory, completing onto a 3-lane result bus.
module exec_unit_bank #(
  parameter int unsigned MEM_LAT = 3,
  parameter int unsigned DEPTH   = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  exec_unit_bank_if.slave bus,
  output logic            err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } st_e;

  logic [1:0]       alu_v_q, alu_v_d;
  logic [1:0][5:0]  alu_rd_q, alu_rd_d;
  logic [1:0][31:0] alu_val_q, alu_val_d;
  logic [1:0][4:0]  alu_rob_q, alu_rob_d;
  logic [1:0]       alu_bad;
  logic [1:0]       is_r, is_i;
  logic [1:0][31:0] opb, res;

  st_e           st_q, st_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          sw_q, sw_d;
  logic [31:0]   wd_q, wd_d;
  logic [5:0]    rd_q, rd_d;
  logic [4:0]    rob_q, rob_d;
  logic [31:0]   rdata_q;
  logic          err_q, err_d;

  logic [31:0] mem [DEPTH];
  logic [31:0] addr2;
  logic        is_mem2, acc2, done, enter_done;

  always_comb begin
    alu_v_d   = '0;
    alu_rd_d  = '0;
    alu_val_d = '0;
    alu_rob_d = '0;
    alu_bad   = '0;
    is_r      = '0;
    is_i      = '0;
    opb       = '0;
    res       = '0;
    for (int k = 0; k < 2; k++) begin
      is_r[k] = bus.iss_opcode[k] == OP_R;
      is_i[k] = bus.iss_opcode[k] == OP_I;
      opb[k]  = is_r[k] ? bus.iss_src2[k] : bus.iss_imm[k];
      case (bus.iss_alu_op[k])
        3'b000:  res[k] = bus.iss_src1[k] + opb[k];
        3'b001:  res[k] = bus.iss_src1[k] - opb[k];
        3'b010:  res[k] = bus.iss_src1[k] ^ opb[k];
        3'b011:  res[k] = $unsigned(
                   $signed(bus.iss_src1[k]) >>> opb[k][4:0]);
        3'b100:  res[k] = bus.iss_src1[k] & opb[k];
        default: res[k] = '0;
      endcase
      alu_v_d[k] = bus.iss_valid[k] & (is_r[k] | is_i[k]);
      alu_bad[k] = bus.iss_valid[k] & ~(is_r[k] | is_i[k]);
      if (alu_v_d[k]) begin
        alu_rd_d[k]  = bus.iss_rd[k];
        alu_val_d[k] = res[k];
        alu_rob_d[k] = bus.iss_rob[k];
      end
    end
  end

  assign addr2   = bus.iss_src1[2] + bus.iss_imm[2];
  assign is_mem2 = (bus.iss_opcode[2] == OP_LW) ||
                   (bus.iss_opcode[2] == OP_SW);
  assign acc2    = bus.iss_valid[2] && (st_q == S_IDLE) && is_mem2;

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    sw_d  = sw_q;
    wd_d  = wd_q;
    rd_d  = rd_q;
    rob_d = rob_q;
    unique case (st_q)
      S_IDLE: begin
        if (acc2) begin
          idx_d = addr2[AW+1:2];
          sw_d  = bus.iss_opcode[2] == OP_SW;
          wd_d  = bus.iss_src2[2];
          rd_d  = bus.iss_rd[2];
          rob_d = bus.iss_rob[2];
          cnt_d = LAT_M1;
          st_d  = (MEM_LAT == 1) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) st_d = S_DONE;
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  assign done       = st_q == S_DONE;
  assign enter_done = (st_d == S_DONE) && !done;

  always_comb begin
    err_d = err_q | (|alu_bad);
    if (bus.iss_valid[2] && (!done && st_q != S_IDLE))
      err_d = 1'b1;
    if (bus.iss_valid[2] && (done || !is_mem2))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_v_q   <= '0;
      alu_rd_q  <= '0;
      alu_val_q <= '0;
      alu_rob_q <= '0;
      st_q      <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sw_q      <= 1'b0;
      wd_q      <= '0;
      rd_q      <= '0;
      rob_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      alu_v_q   <= alu_v_d;
      alu_rd_q  <= alu_rd_d;
      alu_val_q <= alu_val_d;
      alu_rob_q <= alu_rob_d;
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sw_q      <= sw_d;
      wd_q      <= wd_d;
      rd_q      <= rd_d;
      rob_q     <= rob_d;
      err_q     <= err_d;
    end
  end

  // rst_n gate keeps a MEM_LAT=1 store issued during reset out of memory
  always_ff @(posedge clk) begin
    if (enter_done && sw_d && rst_n) mem[idx_d] <= wd_d;
    if (enter_done && !sw_d) rdata_q <= mem[idx_d];
  end

  assign bus.fu_ready  = {st_q == S_IDLE, 2'b11};
  assign bus.cdb_valid = {done, alu_v_q};
  assign bus.cdb_wen   = {done & ~sw_q, alu_v_q};
  assign bus.cdb_rd    = {done ? rd_q : 6'd0, alu_rd_q};
  assign bus.cdb_rob   = {done ? rob_q : 5'd0, alu_rob_q};
  assign bus.cdb_val   = {(done && !sw_q) ? rdata_q : 32'd0,
                          alu_val_q};
  assign err_o         = err_q;

  wire unused = ^{bus.iss_alu_op[2], addr2};
endmodule

// File: tb/tb_exec_unit_bank.sv
// Bench for exec_unit_bank: two instances (MEM_LAT 3 and 1) share
// one randomized stimulus stream and are checked against a model.
module tb_exec_unit_bank;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic err_a, err_b;
  always #5 clk = ~clk;

  exec_unit_bank_if ifa ();
  exec_unit_bank_if ifb ();

  exec_unit_bank #(.MEM_LAT(3), .DEPTH(256)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .err_o(err_a)
  );
  exec_unit_bank #(.MEM_LAT(1), .DEPTH(256)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .err_o(err_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          e;
    logic        wen;
    logic [5:0]  rd;
    logic [4:0]  rob;
    logic [31:0] val;
    logic        sw;
    int          idx;
    logic [31:0] wd;
  } cmp_t;

  int          lat [2] = '{3, 1};
  int          free_edge [2];
  bit          exp_err [2];
  cmp_t        pend [2][3];
  bit          pv [2][3];
  logic [31:0] mem_m [2][256];

  logic [2:0]       s_v;
  logic [2:0][6:0]  s_op;
  logic [2:0][2:0]  s_aop;
  logic [2:0][5:0]  s_rd;
  logic [2:0][31:0] s_s1, s_s2, s_imm;
  logic [2:0][4:0]  s_rob;

  function automatic logic [31:0] alu_ref(input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] b);
    longint sa;
    sa = longint'($signed(a));
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a ^ b;
      3'd3: return 32'(sa >>> b[4:0]);
      3'd4: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [44:0] lane_of(input int d, input int k);
    if (d == 0)
      return {ifa.cdb_valid[k], ifa.cdb_wen[k], ifa.cdb_rd[k],
              ifa.cdb_rob[k], ifa.cdb_val[k]};
    return {ifb.cdb_valid[k], ifb.cdb_wen[k], ifb.cdb_rd[k],
            ifb.cdb_rob[k], ifb.cdb_val[k]};
  endfunction

  function automatic logic [2:0] rdy_of(input int d);
    return (d == 0) ? ifa.fu_ready : ifb.fu_ready;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 0) ? err_a : err_b;
  endfunction

  task automatic clr();
    s_v = '0; s_op = '0; s_aop = '0; s_rd = '0;
    s_s1 = '0; s_s2 = '0; s_imm = '0; s_rob = '0;
  endtask

  task automatic set_lane(input int k, input logic [6:0] op,
      input logic [2:0] f, input logic [5:0] rd,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] imm, input logic [4:0] rob);
    s_v[k] = 1'b1; s_op[k] = op; s_aop[k] = f; s_rd[k] = rd;
    s_s1[k] = a; s_s2[k] = b; s_imm[k] = imm; s_rob[k] = rob;
  endtask

  task automatic drive();
    ifa.iss_valid = s_v;  ifb.iss_valid = s_v;
    ifa.iss_opcode = s_op; ifb.iss_opcode = s_op;
    ifa.iss_alu_op = s_aop; ifb.iss_alu_op = s_aop;
    ifa.iss_rd = s_rd;    ifb.iss_rd = s_rd;
    ifa.iss_src1 = s_s1;  ifb.iss_src1 = s_s1;
    ifa.iss_src2 = s_s2;  ifb.iss_src2 = s_s2;
    ifa.iss_imm = s_imm;  ifb.iss_imm = s_imm;
    ifa.iss_rob = s_rob;  ifb.iss_rob = s_rob;
  endtask

  // Called at a negedge: offers s_* to the next edge, then checks
  // the window that follows that edge.
  task automatic tick();
    int ne;
    logic [31:0] addr;
    logic [44:0] exp;
    ne = cyc + 1;
    drive();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rdy%0d", d), 64'(rdy_of(d)),
            64'({ne >= free_edge[d], 2'b11}));
      for (int k = 0; k < 2; k++) begin
        if (!s_v[k]) continue;
        if (s_op[k] == OP_R || s_op[k] == OP_I) begin
          pend[d][k] = '{e: ne, wen: 1'b1, rd: s_rd[k], rob: s_rob[k],
            val: alu_ref(s_aop[k], s_s1[k],
                         (s_op[k] == OP_R) ? s_s2[k] : s_imm[k]),
            sw: 1'b0, idx: 0, wd: 32'd0};
          pv[d][k] = 1'b1;
        end else exp_err[d] = 1'b1;
      end
      if (s_v[2]) begin
        addr = s_s1[2] + s_imm[2];
        if (ne < free_edge[d]) exp_err[d] = 1'b1;
        else if (s_op[2] == OP_LW || s_op[2] == OP_SW) begin
          pend[d][2] = '{e: ne + lat[d] - 1, wen: s_op[2] == OP_LW,
            rd: s_rd[2], rob: s_rob[2],
            val: (s_op[2] == OP_LW) ? mem_m[d][(addr / 4) % 256] : 0,
            sw: s_op[2] == OP_SW, idx: int'((addr / 4) % 256),
            wd: s_s2[2]};
          pv[d][2] = 1'b1;
          free_edge[d] = ne + lat[d] + 1;
        end else exp_err[d] = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) begin
        exp = '0;
        if (pv[d][k] && pend[d][k].e == cyc) begin
          exp = {1'b1, pend[d][k].wen, pend[d][k].rd,
                 pend[d][k].rob, pend[d][k].val};
          pv[d][k] = 1'b0;
          if (pend[d][k].sw) mem_m[d][pend[d][k].idx] = pend[d][k].wd;
        end
        check($sformatf("cdb%0d_l%0d_c%0d", d, k, cyc),
              64'(lane_of(d, k)), 64'(exp));
      end
      check($sformatf("err%0d", d), 64'(err_of(d)), 64'(exp_err[d]));
    end
  endtask

  task automatic idle(input int n);
    clr();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    clr();
    drive();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 3; k++) pv[d][k] = 1'b0;
      exp_err[d] = 1'b0;
      free_edge[d] = 0;
      check($sformatf("rst_rdy%0d", d), 64'(rdy_of(d)), 64'(3'b111));
      check($sformatf("rst_err%0d", d), 64'(err_of(d)), 64'd0);
      for (int k = 0; k < 3; k++)
        check($sformatf("rst_cdb%0d_l%0d", d, k),
              64'(lane_of(d, k)), 64'd0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_addr(input int idx);
    return ($urandom << 10) | (idx << 2) | ($urandom % 4);
  endfunction

  logic [31:0] a_tmp, old_a;

  initial begin
    clr();
    drive();
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      clr();
      a_tmp = $urandom;
      set_lane(2, OP_SW, 3'd0, 6'd0, a_tmp, $urandom,
               rnd_addr(i) - a_tmp, 5'(i));
      tick();
      idle(4);
    end

    clr();
    set_lane(0, OP_R, 3'd0, 6'd3, 32'd5, 32'd7, 32'd0, 5'd4);
    tick();
    check("add_valid", 64'(ifa.cdb_valid), 64'(3'b001));
    check("add_val", 64'(ifa.cdb_val[0]), 64'd12);

    clr();
    set_lane(1, OP_R, 3'd3, 6'd1, 32'h80000000, 32'd4, 32'd0, 5'd1);
    tick();
    check("sra_val", 64'(ifa.cdb_val[1]), 64'hF8000000);
    clr();
    set_lane(1, OP_I, 3'd4, 6'd2, 32'hFF, 32'd0, 32'h0F, 5'd2);
    tick();
    check("and_val", 64'(ifa.cdb_val[1]), 64'h0000000F);

    clr();
    set_lane(2, OP_SW, 3'd0, 6'd7, 32'h10, 32'hDEADBEEF, 32'd0, 5'd9);
    tick();
    idle(2);
    check("sw_pulse", 64'({ifa.cdb_valid[2], ifa.cdb_wen[2]}),
          64'(2'b10));
    idle(1);
    clr();
    set_lane(2, OP_LW, 3'd0, 6'd8, 32'h10, 32'd0, 32'd0, 5'd10);
    tick();
    idle(2);
    check("lw_val", 64'(ifa.cdb_val[2]), 64'hDEADBEEF);
    idle(1);

    clr();
    set_lane(2, OP_SW, 3'd0, 6'd0, 32'h20, 32'h1234, 32'd0, 5'd3);
    tick();
    clr();
    set_lane(2, OP_LW, 3'd0, 6'd5, 32'h20, 32'd0, 32'd0, 5'd6);
    tick();
    check("busy_err", 64'(err_a), 64'd1);
    idle(5);
    check("err_sticky", 64'(err_a), 64'd1);
    do_reset();

    clr();
    set_lane(0, OP_R, 3'd1, 6'd11, 32'd3, 32'd9, 32'd0, 5'd21);
    set_lane(1, OP_I, 3'd2, 6'd12, 32'hF0F0, 32'd0, 32'hFFFF, 5'd22);
    set_lane(2, OP_LW, 3'd0, 6'd13, 32'hC, 32'd0, 32'd0, 5'd23);
    tick();
    check("all3_valid", 64'(ifb.cdb_valid), 64'(3'b111));
    idle(4);

    old_a = mem_m[0][5];
    clr();
    set_lane(2, OP_SW, 3'd0, 6'd0, 32'h14, 32'hCAFEF00D, 32'd0, 5'd7);
    tick();
    do_reset();
    idle(4);
    clr();
    set_lane(2, OP_LW, 3'd0, 6'd9, 32'h400, 32'd0, 32'h14, 5'd8);
    tick();
    idle(2);
    check("rst_sw_drop", 64'(ifa.cdb_val[2]), 64'(old_a));
    idle(1);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      clr();
      for (int k = 0; k < 2; k++) begin
        if ($urandom % 4 != 0) begin
          set_lane(k, ($urandom % 16 == 0) ? OP_BAD :
                   (($urandom % 2 != 0) ? OP_R : OP_I),
                   3'($urandom), 6'($urandom), $urandom,
                   ($urandom % 2 != 0) ? ($urandom % 40) : $urandom,
                   $urandom, 5'($urandom));
        end
      end
      if ($urandom % 2 != 0) begin
        a_tmp = $urandom;
        set_lane(2, ($urandom % 16 == 0) ? OP_R :
                 (($urandom % 2 != 0) ? OP_LW : OP_SW),
                 3'($urandom), 6'($urandom), a_tmp, $urandom,
                 rnd_addr($urandom % 8) - a_tmp, 5'($urandom));
      end
      tick();
    end
    idle(5);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
